// File: rtl/mem_access_arbiter.sv
// Arbiter between the IF-stage fetch port and the MEM-stage load/store port
// for a single-ported unified memory. One access is in flight at a time. Data
// requests win by default, and a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data wins.
module mem_access_arbiter #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_funct3,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [2:0]        mem_funct3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   // Latched access, captured on the grant cycle
   logic              owner_d;     // 1 = data port owns the access
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [DATA_W-1:0] wdata_q;

   logic [STV_W-1:0]  starve_cnt;
   logic [LAT_W-1:0]  lat_cnt;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic              force_fetch;
   logic              done;
   logic [DATA_W-1:0] resp_data;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state, grants, memory strobes and completion pulses
   always_comb begin
      state_nxt   = state;
      force_fetch = (starve_cnt == STV_W'(STARVE_MAX)) && if_req;
      if_gnt      = 1'b0;
      d_gnt       = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_funct3  = '0;
      mem_addr    = '0;
      mem_wdata   = '0;
      done        = 1'b0;
      unique case (state)
         IDLE: begin
            d_gnt  = d_req && !force_fetch;
            if_gnt = if_req && (!d_req || force_fetch);
            if (if_gnt || d_gnt) state_nxt = ISSUE;
         end
         ISSUE: begin
            mem_en     = 1'b1;
            mem_we     = we_q;
            mem_funct3 = funct3_q;
            mem_addr   = addr_q;
            mem_wdata  = wdata_q;
            state_nxt  = WAIT;
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Completion: rdata is presented straight from memory on the pulse cycle
   // and held in a register afterwards, so the port reads valid data on the
   // pulse and keeps it until the next completion for that port.
   always_comb begin
      resp_data = we_q ? '0 : mem_rdata;
      if_rvalid = done && !owner_d;
      d_rvalid  = done && owner_d;
      if_rdata  = if_rvalid ? resp_data : if_rdata_q;
      d_rdata   = d_rvalid  ? resp_data : d_rdata_q;
      busy      = (state != IDLE);
   end

   // Capture the winning request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_d  <= 1'b0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         funct3_q <= '0;
         wdata_q  <= '0;
      end else if (if_gnt) begin
         owner_d  <= 1'b0;
         addr_q   <= if_addr;
         we_q     <= 1'b0;
         funct3_q <= 3'b010;
         wdata_q  <= '0;
      end else if (d_gnt) begin
         owner_d  <= 1'b1;
         addr_q   <= d_addr;
         we_q     <= d_we;
         funct3_q <= d_funct3;
         wdata_q  <= d_wdata;
      end
   end

   // Count data wins that happened while fetch was waiting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (if_gnt) begin
         starve_cnt <= '0;
      end else if (d_gnt && if_req && (starve_cnt != STV_W'(STARVE_MAX))) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Memory latency countdown
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_cnt <= '0;
      end else if (state == ISSUE) begin
         lat_cnt <= LAT_W'(MEM_LAT - 1);
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
         lat_cnt <= lat_cnt - 1'b1;
      end
   end

   // Hold the last returned data per port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (if_rvalid) if_rdata_q <= resp_data;
         if (d_rvalid)  d_rdata_q  <= resp_data;
      end
   end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Testbench for mem_access_arbiter: a MEM_LAT=1 instance checked by a
// scoreboard monitor, and a MEM_LAT=3 instance driven with directed checks.
module tb_mem_access_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- instance A: MEM_LAT = 1 ----------------
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [7:0]  if_addr = '0;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [2:0]  d_funct3 = '0;
   logic [7:0]  d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en, mem_we;
   logic [2:0]  mem_funct3;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   mem_access_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   // ---------------- instance B: MEM_LAT = 3 ----------------
   logic        b_rst = 1'b0;
   logic        b_if_req = 1'b0;
   logic [7:0]  b_if_addr = '0;
   logic        b_if_gnt, b_if_rvalid;
   logic [31:0] b_if_rdata;
   logic        b_d_req = 1'b0;
   logic        b_d_we = 1'b0;
   logic [2:0]  b_d_funct3 = '0;
   logic [7:0]  b_d_addr = '0;
   logic [31:0] b_d_wdata = '0;
   logic        b_d_gnt, b_d_rvalid;
   logic [31:0] b_d_rdata;
   logic        b_mem_en, b_mem_we;
   logic [2:0]  b_mem_funct3;
   logic [7:0]  b_mem_addr;
   logic [31:0] b_mem_wdata;
   logic [31:0] b_mem_rdata;
   logic        b_busy;

   mem_access_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk(clk), .rst(b_rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .d_req(b_d_req), .d_we(b_d_we), .d_funct3(b_d_funct3), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_funct3(b_mem_funct3), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   // ---------------- memory models ----------------
   // Preload pattern: word at byte address a is 32'hC000_00aa, except 0x04.
   logic [31:0] mem1 [256];
   logic [31:0] mem3 [256];
   logic [31:0] pipe3 [3];

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) mem1[i] <= 32'hC000_0000 | 32'(i);
         mem1[4] <= 32'h0050_0093;
      end else if (mem_en && mem_we) begin
         mem1[mem_addr] <= mem_wdata;
      end
   end

   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= mem1[mem_addr];
      else                   mem_rdata <= 32'hBAD0_0001;
   end

   always @(posedge clk) begin
      if (!b_rst) begin
         for (int i = 0; i < 256; i++) mem3[i] <= 32'hC000_0000 | 32'(i);
      end else if (b_mem_en && b_mem_we) begin
         mem3[b_mem_addr] <= b_mem_wdata;
      end
   end

   always @(posedge clk) begin
      pipe3[0] <= (b_mem_en && !b_mem_we) ? mem3[b_mem_addr] : 32'hBAD0_0003;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign b_mem_rdata = pipe3[2];

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic bad(input string name, input string what);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %s (t=%0t)", name, what, $time);
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [7:0]  addr;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] wdata;
   } mem_exp_t;

   mem_exp_t    mem_q[$];
   logic        gnt_q[$];     // 1 = data port expected to win
   logic [31:0] if_rsp_q[$];
   logic [31:0] d_rsp_q[$];
   int          gnt_cyc = 0;

   always @(negedge clk) begin : monitor
      mem_exp_t    e;
      logic        g;
      logic [31:0] r;
      #2;
      if (rst) begin
         if (if_gnt && d_gnt) begin
            bad("dual_gnt", "if_gnt and d_gnt both high, required at most one");
         end else if (if_gnt || d_gnt) begin
            if (gnt_q.size() == 0) begin
               bad("unexpected_gnt", $sformatf("if_gnt=%b d_gnt=%b, required none", if_gnt, d_gnt));
            end else begin
               g = gnt_q.pop_front();
               chk1("gnt_owner_is_data", d_gnt, g);
            end
            gnt_cyc = cyc;
         end
         if (mem_en) begin
            if (mem_q.size() == 0) begin
               bad("unexpected_mem_en", $sformatf("mem_en=1 addr=%h, required no access", mem_addr));
            end else begin
               e = mem_q.pop_front();
               chk("mem_addr", 32'(mem_addr), 32'(e.addr));
               chk1("mem_we", mem_we, e.we);
               chk("mem_funct3", 32'(mem_funct3), 32'(e.f3));
               if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            end
            chk("mem_en_latency", 32'(cyc - gnt_cyc), 32'd1);
         end
         if (if_rvalid) begin
            if (if_rsp_q.size() == 0) begin
               bad("unexpected_if_rvalid", $sformatf("if_rvalid=1 rdata=%h, required none", if_rdata));
            end else begin
               r = if_rsp_q.pop_front();
               chk("if_rdata", if_rdata, r);
            end
            chk("if_rvalid_latency", 32'(cyc - gnt_cyc), 32'd2);
         end
         if (d_rvalid) begin
            if (d_rsp_q.size() == 0) begin
               bad("unexpected_d_rvalid", $sformatf("d_rvalid=1 rdata=%h, required none", d_rdata));
            end else begin
               r = d_rsp_q.pop_front();
               chk("d_rdata", d_rdata, r);
            end
            chk("d_rvalid_latency", 32'(cyc - gnt_cyc), 32'd2);
         end
      end
   end

   // ---------------- drivers for instance A ----------------
   task automatic fetch(input logic [7:0] a, input logic [31:0] exp);
      int n;
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = a;
      if_rsp_q.push_back(exp);
      n = 0;
      #1;
      while (!if_gnt && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!if_gnt) bad("if_gnt_timeout", "no if_gnt within 100 cycles");
      else         mem_q.push_back('{a, 1'b0, 3'b010, 32'h0});
      @(posedge clk);
      #1;
      if_req = 1'b0;
   endtask

   task automatic dacc(input logic we, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] exp);
      int n;
      @(negedge clk);
      d_req    = 1'b1;
      d_we     = we;
      d_funct3 = f3;
      d_addr   = a;
      d_wdata  = wd;
      d_rsp_q.push_back(exp);
      n = 0;
      #1;
      while (!d_gnt && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!d_gnt) bad("d_gnt_timeout", "no d_gnt within 100 cycles");
      else        mem_q.push_back('{a, we, f3, wd});
      @(posedge clk);
      #1;
      d_req = 1'b0;
   endtask

   task automatic run_lat1();
      logic [2:0] f3tab [5];
      f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      // Reset state
      #12;
      chk("reset_strobes", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}), 32'h0);
      chk("reset_if_rdata", if_rdata, 32'h0);
      chk("reset_d_rdata", d_rdata, 32'h0);
      chk("reset_mem_bus", {mem_addr, mem_wdata[23:0]} | 32'(mem_funct3), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Lone fetch
      gnt_q.push_back(1'b0);
      fetch(8'h04, 32'h0050_0093);

      // Store then load back
      gnt_q.push_back(1'b1);
      dacc(1'b1, 3'b010, 8'h10, 32'hDEAD_BEEF, 32'h0);
      gnt_q.push_back(1'b1);
      dacc(1'b0, 3'b010, 8'h10, 32'h0, 32'hDEAD_BEEF);

      // Contention: D,D,D,D,F,D,D,D,D,F
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++) gnt_q.push_back(1'b1);
         gnt_q.push_back(1'b0);
      end
      fork
         begin
            for (int k = 0; k < 2; k++) fetch(8'(8'h40 + 4 * k), 32'(32'hC000_0040 + 4 * k));
         end
         begin
            for (int k = 0; k < 8; k++) dacc(1'b0, f3tab[k % 5], 8'(8'h20 + k), 32'h0, 32'(32'hC000_0020 + k));
         end
      join

      // Data request raised while busy and withdrawn before IDLE
      gnt_q.push_back(1'b0);
      fork
         fetch(8'h08, 32'hC000_0008);
         begin
            @(negedge clk);
            @(negedge clk);
            d_req    = 1'b1;
            d_we     = 1'b1;
            d_funct3 = 3'b010;
            d_addr   = 8'h50;
            d_wdata  = 32'h1234_5678;
            @(negedge clk);
            d_req    = 1'b0;
         end
      join
      // The withdrawn store must not have reached memory
      gnt_q.push_back(1'b1);
      dacc(1'b0, 3'b010, 8'h50, 32'h0, 32'hC000_0050);

      repeat (4) @(negedge clk);
      #3;
      chk("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
      chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
      chk("if_rsp_q_drained", 32'(if_rsp_q.size()), 32'd0);
      chk("d_rsp_q_drained", 32'(d_rsp_q.size()), 32'd0);
   endtask

   // ---------------- directed sequence for instance B ----------------
   task automatic run_lat3();
      repeat (2) @(negedge clk);
      b_rst = 1'b1;
      // Single load at T
      @(negedge clk);
      b_d_req    = 1'b1;
      b_d_we     = 1'b0;
      b_d_funct3 = 3'b010;
      b_d_addr   = 8'h30;
      #1;
      chk1("lat3_d_gnt_T", b_d_gnt, 1'b1);
      @(posedge clk);
      #1;
      b_d_req   = 1'b0;
      b_if_req  = 1'b1;
      b_if_addr = 8'h34;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         #1;
         chk1($sformatf("lat3_mem_en_T%0d", k), b_mem_en, (k == 1));
         chk1($sformatf("lat3_if_gnt_busy_T%0d", k), b_if_gnt, 1'b0);
         chk1($sformatf("lat3_d_rvalid_T%0d", k), b_d_rvalid, (k == 4));
      end
      chk("lat3_d_rdata", b_d_rdata, 32'hC000_0030);
      @(negedge clk);
      #1;
      chk1("lat3_if_gnt_T5", b_if_gnt, 1'b1);
      @(posedge clk);
      #1;
      b_if_req = 1'b0;
      @(negedge clk);
      #1;
      chk("lat3_fetch_issue", 32'({b_mem_en, b_mem_we, b_mem_funct3, b_mem_addr}), 32'({1'b1, 1'b0, 3'b010, 8'h34}));
      // Reset in the first WAIT cycle of the fetch
      @(negedge clk);
      b_rst = 1'b0;
      #1;
      chk("lat3_reset_strobes", 32'({b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy}), 32'h0);
      chk("lat3_reset_d_rdata", b_d_rdata, 32'h0);
      chk("lat3_reset_if_rdata", b_if_rdata, 32'h0);
      chk("lat3_reset_mem_bus", 32'({b_mem_funct3, b_mem_addr}) | b_mem_wdata, 32'h0);
      @(negedge clk);
      b_rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk("lat3_no_rvalid_after_reset", 32'({b_if_rvalid, b_d_rvalid}), 32'h0);
      end
      b_if_req  = 1'b1;
      b_if_addr = 8'h38;
      #1;
      chk1("lat3_first_gnt_after_reset", b_if_gnt, 1'b1);
      @(posedge clk);
      #1;
      b_if_req = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk1("lat3_if_rvalid", b_if_rvalid, 1'b1);
      chk("lat3_if_rdata", b_if_rdata, 32'hC000_0038);
   endtask

   initial begin
      fork
         run_lat1();
         run_lat3();
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
